booth_pp_accumulator: RTL and testbench

Sequential radix-4 Booth partial-product generator and accumulator for the 8x8 signed multiplier. It sits directly downstream of the Booth encoder: it consumes the encoder's four per-digit control triplets (double, invert, zero) together with the signed multiplicand X. It forms one shifted partial product per cycle and accumulates them into a 16-bit signed product. The result is returned over a valid/ready handshake.

---
 rtl/booth_pp_accumulator_if.sv | 25 ++
 rtl/booth_pp_accumulator.sv | 111 +++++++++++
 tb/tb_booth_pp_accumulator.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_pp_accumulator_if.sv
// Operand/control bundle and product bus of the Booth partial-product accumulator.
interface booth_pp_accumulator_if;
    // Valid/ready: a transfer happens on a rising edge where valid && ready are
    // both high. The sender holds its payload stable and keeps valid high until
    // that edge. Ready is never derived combinationally from valid.
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  X;
    logic [3:0]  double_X;
    logic [3:0]  invert_X;
    logic [3:0]  zero_X;
    logic [15:0] product;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output in_valid, X, double_X, invert_X, zero_X, out_ready,
        input  in_ready, product, out_valid
    );

    modport slave (
        input  in_valid, X, double_X, invert_X, zero_X, out_ready,
        output in_ready, product, out_valid
    );
endinterface

// File: rtl/booth_pp_accumulator.sv
// Sequential radix-4 Booth partial-product accumulator for an 8x8 signed multiply.
// Define BOOTH_PP_DUAL_EN to add two partial products per cycle (latency 2 instead of 4).
module booth_pp_accumulator (
    input  logic                   clk,
    input  logic                   rst,
    booth_pp_accumulator_if.slave  bus,
    output logic [1:0]             state_dbg
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  x_q;
    logic [3:0]  dbl_q;
    logic [3:0]  inv_q;
    logic [3:0]  zero_q;
    logic [15:0] acc;
    logic [15:0] acc_next;
    logic [1:0]  cnt;
    logic [1:0]  cnt_step;
    logic        last_digit;

    // Partial product of one Booth digit, already weighted by 4^digit.
    function automatic logic [15:0] shifted_pp(input logic [7:0] x, input logic dbl,
                                               input logic inv, input logic zro,
                                               input logic [1:0] digit);
        logic [15:0] xs;
        logic [15:0] m;
        logic [15:0] p;
        xs = {{8{x[7]}}, x};
        m  = dbl ? (xs << 1) : xs;
        p  = zro ? 16'h0000 : (inv ? (16'h0000 - m) : m);
        return p << {digit, 1'b0};
    endfunction

`ifdef BOOTH_PP_DUAL_EN
    logic [1:0] cnt_hi;

    always_comb begin
        cnt_hi     = cnt | 2'b01;
        acc_next   = acc
                   + shifted_pp(x_q, dbl_q[cnt], inv_q[cnt], zero_q[cnt], cnt)
                   + shifted_pp(x_q, dbl_q[cnt_hi], inv_q[cnt_hi], zero_q[cnt_hi], cnt_hi);
        cnt_step   = 2'd2;
        last_digit = (cnt == 2'd2);
    end
`else
    always_comb begin
        acc_next   = acc + shifted_pp(x_q, dbl_q[cnt], inv_q[cnt], zero_q[cnt], cnt);
        cnt_step   = 2'd1;
        last_digit = (cnt == 2'd3);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            x_q           <= 8'h00;
            dbl_q         <= 4'h0;
            inv_q         <= 4'h0;
            zero_q        <= 4'h0;
            acc           <= 16'h0000;
            cnt           <= 2'd0;
            bus.product   <= 16'h0000;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        x_q          <= bus.X;
                        dbl_q        <= bus.double_X;
                        inv_q        <= bus.invert_X;
                        zero_q       <= bus.zero_X;
                        acc          <= 16'h0000;
                        cnt          <= 2'd0;
                        bus.in_ready <= 1'b0;
                        state        <= ACC;
                    end
                end
                ACC: begin
                    acc <= acc_next;
                    cnt <= cnt + cnt_step;
                    if (last_digit) begin
                        bus.product   <= acc_next;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    // in_ready rises only after the handshake edge, never on it.
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;
endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Directed and randomized checks of booth_pp_accumulator (both BOOTH_PP_DUAL_EN builds).
module tb_booth_pp_accumulator;
`ifdef BOOTH_PP_DUAL_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 4;
`endif
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  state_dbg;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];

    booth_pp_accumulator_if bus ();

    booth_pp_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Golden radix-4 Booth encoder: digit j looks at y[2j+1], y[2j], y[2j-1].
    function automatic void booth_encode(input logic [7:0] y, output logic [3:0] d,
                                         output logic [3:0] i, output logic [3:0] z);
        logic [8:0] ye;
        logic [2:0] bits;
        ye = {y, 1'b0};
        d = 4'h0; i = 4'h0; z = 4'h0;
        for (int j = 0; j < 4; j++) begin
            bits = ye[2*j +: 3];
            case (bits)
                3'b000, 3'b111: z[j] = 1'b1;
                3'b011:         d[j] = 1'b1;
                3'b100:         begin d[j] = 1'b1; i[j] = 1'b1; end
                3'b101, 3'b110: i[j] = 1'b1;
                default:        ;
            endcase
        end
    endfunction

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        logic signed [15:0] xe;
        logic signed [15:0] ye;
        xe = {{8{x[7]}}, x};
        ye = {{8{y[7]}}, y};
        return xe * ye;
    endfunction

    // Presents a bundle and returns just after the accepting edge.
    task automatic drive_bundle(input logic [7:0] x, input logic [3:0] d,
                                input logic [3:0] i, input logic [3:0] z);
        int waited;
        @(posedge clk);
        #1;
        bus.X = x; bus.double_X = d; bus.invert_X = i; bus.zero_X = z;
        bus.in_valid = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 50) begin
                checks++; errors++;
                $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Counts edges from accept until out_valid is seen; ends at that negedge.
    task automatic wait_out(output int lat);
        lat = 0;
        forever begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.out_valid || lat > 20) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.X = 8'h00; bus.double_X = 4'h0; bus.invert_X = 4'h0; bus.zero_X = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.product, state_dbg} !== {1'b1, 1'b0, 16'h0000, ST_IDLE}) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b product=%h state=%0d, required 1 0 0000 0",
                     bus.in_ready, bus.out_valid, bus.product, state_dbg);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_directed();
        // Controls for Y=5, Y=-128 (digit3 = -2) and Y=127 (digits -1,0,0,+2).
        logic [7:0]  xs[3]  = '{8'h03, 8'h80, 8'h80};
        logic [3:0]  ds[3]  = '{4'b1100, 4'b1000, 4'b1000};
        logic [3:0]  is[3]  = '{4'b0000, 4'b1000, 4'b0001};
        logic [3:0]  zs[3]  = '{4'b1100, 4'b0111, 4'b0110};
        logic [15:0] exps[3] = '{16'h000F, 16'h4000, 16'hC080};
        logic        pre[3] = '{1'b0, 1'b0, 1'b1};
        int lat;
        for (int k = 0; k < 3; k++) begin
            bus.out_ready = pre[k];
            drive_bundle(xs[k], ds[k], is[k], zs[k]);
            wait_out(lat);
            checks++;
            if (lat !== LAT) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d cycles, required %0d", k, lat, LAT);
            end
            checks++;
            if (bus.product !== exps[k]) begin
                errors++;
                $display("FAIL directed_product[%0d]: got %h, required %h", k, bus.product, exps[k]);
            end
            if (!pre[k]) begin
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
            @(posedge clk);
            #1 bus.out_ready = 1'b0;
            @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
                errors++;
                $display("FAIL directed_drain[%0d]: out_valid=%b in_ready=%b, required 0 1",
                         k, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_reset_mid_acc();
        int lat;
        drive_bundle(8'h05, 4'b0000, 4'b1010, 4'b0000);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.product, state_dbg} !== {1'b0, 1'b1, 16'h0000, ST_IDLE}) begin
            errors++;
            $display("FAIL reset_mid_acc: out_valid=%b in_ready=%b product=%h state=%0d, required 0 1 0000 0",
                     bus.out_valid, bus.in_ready, bus.product, state_dbg);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        drive_bundle(8'h03, 4'b1100, 4'b0000, 4'b1100);
        wait_out(lat);
        checks++;
        if (lat !== LAT || bus.product !== 16'h000F) begin
            errors++;
            $display("FAIL after_reset_product: got %h after %0d cycles, required 000F after %0d",
                     bus.product, lat, LAT);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat;
        drive_bundle(8'h7F, 4'b0000, 4'b0000, 4'b1111);
        wait_out(lat);
        checks++;
        if (lat !== LAT || bus.product !== 16'h0000) begin
            errors++;
            $display("FAIL zero_product: got %h after %0d cycles, required 0000 after %0d",
                     bus.product, lat, LAT);
        end
        bus.X = 8'h11; bus.double_X = 4'h0; bus.invert_X = 4'h0; bus.zero_X = 4'h0;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.product, state_dbg} !== {1'b1, 1'b0, 16'h0000, ST_DONE}) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: out_valid=%b in_ready=%b product=%h state=%0d, required 1 0 0000 2",
                         c, bus.out_valid, bus.in_ready, bus.product, state_dbg);
            end
        end
        // in_valid stays high across the handshake edge; it must not be taken there.
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.in_ready, state_dbg} !== {1'b0, 1'b1, ST_IDLE}) begin
            errors++;
            $display("FAIL no_same_cycle_accept: out_valid=%b in_ready=%b state=%0d, required 0 1 0",
                     bus.out_valid, bus.in_ready, state_dbg);
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 200;
        fork
            begin
                logic [7:0] x;
                logic [7:0] y;
                logic [3:0] d;
                logic [3:0] i;
                logic [3:0] z;
                for (int n = 0; n < N; n++) begin
                    x = 8'($urandom_range(0, 255));
                    y = 8'($urandom_range(0, 255));
                    if (n == 0) begin x = 8'h80; y = 8'h80; end
                    if (n == 1) begin x = 8'h7F; y = 8'h80; end
                    booth_encode(y, d, i, z);
                    exp_q.push_back(ref_mul(x, y));
                    drive_bundle(x, d, i, z);
                end
            end
            begin
                int got;
                int cyc;
                logic [15:0] exp_v;
                got = 0;
                cyc = 0;
                while (got < N && cyc < N * 30) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    cyc++;
                    if (bus.out_valid && bus.out_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL b2b_unexpected: product %h with empty expected queue", bus.product);
                        end else begin
                            exp_v = exp_q.pop_front();
                            if (bus.product !== exp_v) begin
                                errors++;
                                $display("FAIL b2b_product[%0d]: got %h, required %h", got, bus.product, exp_v);
                            end
                        end
                        got++;
                    end
                end
                checks++;
                if (got != N) begin
                    errors++;
                    $display("FAIL b2b_count: received %0d results, required %0d", got, N);
                end
            end
        join
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_leftover: %0d expected results never arrived, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_acc();
        test_backpressure();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
